// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage and its neighbours.
//   This package is the single place where the bus widths and the field
//   order of the IF-facing buses are defined; every consumer imports it.
//
//   br_bus       (BR_BUS_WD = 34)       {br_stall[33], br_taken[32], br_target[31:0]}
//   fs_to_ds_bus (FS_TO_DS_BUS_WD = 64) {fs_inst[63:32], fs_pc[31:0]}
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam int BR_BUS_WD       = 34;
  localparam int FS_TO_DS_BUS_WD = 64;

  // Boot vector of the MIPS kseg1 reset exception.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Branch information returned from decode. The first member lands in the
  // most significant bit of the packed vector.
  typedef struct packed {
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
  } br_bus_t;

  // Payload handed from IF to decode.
  typedef struct packed {
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
  } fs_to_ds_bus_t;

  // Sequential successor of a fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of a MIPS-style pipeline with a single branch
//   delay slot. Decode resolves a branch while its delay slot sits in IF, so
//   the branch target is the address requested right after the slot.
//
//   Pre-IF picks the next PC and issues a synchronous read to the
//   instruction SRAM (one cycle latency); IF holds the fetched PC and hands
//   {inst, pc} to decode through a valid/allowin handshake.
//
// Parameters
//   RESET_PC         address of the first fetched instruction
//
// Ports
//   clk              clock, single domain
//   reset            synchronous, active-high reset
//   ds_allowin       decode can accept an instruction this cycle
//   br_bus           {br_stall, br_taken, br_target} from decode
//   fs_to_ds_valid   IF holds a valid instruction for decode
//   fs_to_ds_bus     {fs_inst, fs_pc} to decode
//   inst_sram_en     read request, address sampled at the clock edge
//   inst_sram_wen    write byte enables, always 0
//   inst_sram_addr   read address (nextpc)
//   inst_sram_wdata  write data, always 0
//   inst_sram_rdata  read data for the address requested the previous cycle
//
// Build option
//   FS_INST_BUF_EN   when defined, a holding register captures the fetched
//                    instruction while decode stalls, so the SRAM is free to
//                    change rdata without a request. When undefined, the SRAM
//                    must hold rdata stable while inst_sram_en is low.
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  br_bus_t       br;
  fs_to_ds_bus_t fs_bus;

  logic        to_fs_valid;
  logic        br_redirect;
  logic [31:0] nextpc;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] fs_inst;

  logic        bt_valid;
  logic [31:0] bt_target;

  assign br = br_bus;

  // ---------------------------------------------------------------------
  // Pre-IF: next-PC selection and SRAM request
  // ---------------------------------------------------------------------

  // While decode is stalled on a branch operand nothing is fetched; the
  // target is only trusted once br_stall has dropped.
  assign to_fs_valid = ~reset & ~br.br_stall;
  assign br_redirect = br.br_taken & ~br.br_stall;

  // A buffered target wins over a live one: it belongs to an older branch
  // whose redirect could not be issued when decode announced it.
  always_comb begin
    nextpc = seq_pc(fs_pc);
    if (bt_valid) begin
      nextpc = bt_target;
    end else if (br_redirect) begin
      nextpc = br.br_target;
    end
  end

  assign inst_sram_en    = to_fs_valid & fs_allowin;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  // ---------------------------------------------------------------------
  // IF stage registers and handshake
  // ---------------------------------------------------------------------

  // The SRAM answers in exactly one cycle, so IF is always ready to pass on.
  assign fs_ready_go    = 1'b1;
  assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid & fs_ready_go;

  // fs_pc starts one word below the boot vector so that the sequential
  // successor chosen by pre-IF after reset is RESET_PC itself. When IF
  // drains during a branch stall, fs_valid drops (bubble) but fs_pc is
  // kept, since it still anchors the sequential successor.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      if (to_fs_valid) begin
        fs_pc <= nextpc;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Branch target buffer
  // ---------------------------------------------------------------------

  // Decode may report a taken branch in a cycle where IF cannot issue a
  // request (IF full and decode blocked). The target is parked here and
  // replayed on the next issued request, after which it is dropped. A second
  // taken report while a target is parked is the same branch seen again and
  // must not overwrite it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bt_valid  <= 1'b0;
      bt_target <= 32'h0;
    end else if (bt_valid) begin
      if (inst_sram_en) begin
        bt_valid <= 1'b0;
      end
    end else if (br_redirect & ~inst_sram_en) begin
      bt_valid  <= 1'b1;
      bt_target <= br.br_target;
    end
  end

  // ---------------------------------------------------------------------
  // Instruction source for decode
  // ---------------------------------------------------------------------
`ifdef FS_INST_BUF_EN
  logic [31:0] inst_buf;
  logic        buf_valid;

  // On the first stalled cycle rdata still belongs to fs_pc (it was
  // requested on the cycle fs_pc was loaded), so it is captured then and
  // served from the buffer until IF hands the instruction off.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
    end else if (fs_valid & ds_allowin) begin
      buf_valid <= 1'b0;
    end else if (fs_valid & ~ds_allowin & ~buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end

  assign fs_inst = buf_valid ? inst_buf : inst_sram_rdata;
`else
  assign fs_inst = inst_sram_rdata;
`endif

  assign fs_bus.fs_inst = fs_inst;
  assign fs_bus.fs_pc   = fs_pc;
  assign fs_to_ds_bus   = fs_bus;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Directed bench for if_stage. A one-cycle-latency SRAM model returns a
//   fixed function of the requested address. Each applyStimulus call drives
//   one cycle of inputs just after a rising edge and returns at the falling
//   edge, where the outputs for that cycle are compared against hand-worked
//   values. With FS_INST_BUF_EN defined, the SRAM model scrambles rdata on
//   every cycle without a request.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  logic saw_0c = 1'b0;

  if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Contents of the instruction memory at a given address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3C3C_A5A5;
  endfunction

  // Instruction SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (inst_sram_en) begin
      inst_sram_rdata <= memf(inst_sram_addr);
    end else begin
`ifdef FS_INST_BUF_EN
      inst_sram_rdata <= $urandom;
`else
      inst_sram_rdata <= inst_sram_rdata;
`endif
    end
  end

  // The delay slot after the branch at BFC00008 must be the only one fetched.
  always @(posedge clk) begin
    if (inst_sram_en && inst_sram_addr == 32'hBFC0_000C) begin
      saw_0c <= 1'b1;
    end
  end

  task automatic applyStimulus(input logic rst, input logic allow,
                               input logic stall, input logic taken,
                               input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset      = rst;
    ds_allowin = allow;
    br_bus     = {stall, taken, tgt};
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_bus     = '0;

    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_valid", 32'(fs_to_ds_valid), 32'd0);
    checkOutput("rst_en",    32'(inst_sram_en),   32'd0);
    checkOutput("rst_pc",    fs_to_ds_bus[31:0],  32'hBFBF_FFFC);
    checkOutput("wen",       32'(inst_sram_wen),  32'd0);
    checkOutput("wdata",     inst_sram_wdata,     32'd0);

    // 1: sequential fetch after reset release
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_en0",    32'(inst_sram_en),   32'd1);
    checkOutput("t1_addr0",  inst_sram_addr,      32'hBFC0_0000);
    checkOutput("t1_valid0", 32'(fs_to_ds_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_addr1",  inst_sram_addr,      32'hBFC0_0004);
    checkOutput("t1_valid1", 32'(fs_to_ds_valid), 32'd1);
    checkOutput("t1_pc1",    fs_to_ds_bus[31:0],  32'hBFC0_0000);
    checkOutput("t1_inst1",  fs_to_ds_bus[63:32], memf(32'hBFC0_0000));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_addr2",  inst_sram_addr,      32'hBFC0_0008);
    checkOutput("t1_pc2",    fs_to_ds_bus[31:0],  32'hBFC0_0004);

    // 2: taken branch while the delay slot BFC00008 sits in IF
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC0_0100);
    checkOutput("t2_addr",   inst_sram_addr,      32'hBFC0_0100);
    checkOutput("t2_slot",   fs_to_ds_bus[31:0],  32'hBFC0_0008);
    checkOutput("t2_sv",     32'(fs_to_ds_valid), 32'd1);

    // Redirect to BFC00010 to set up the decode stall
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC0_0010);
    checkOutput("t2_pc",     fs_to_ds_bus[31:0],  32'hBFC0_0100);
    checkOutput("t2_inst",   fs_to_ds_bus[63:32], memf(32'hBFC0_0100));
    checkOutput("t2_addr2",  inst_sram_addr,      32'hBFC0_0010);

    // 3: decode blocked for 3 cycles with fs_pc = BFC00010
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("t3_en",   32'(inst_sram_en),   32'd0);
      checkOutput("t3_pc",   fs_to_ds_bus[31:0],  32'hBFC0_0010);
      checkOutput("t3_inst", fs_to_ds_bus[63:32], memf(32'hBFC0_0010));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_rel_addr", inst_sram_addr,      32'hBFC0_0014);
    checkOutput("t3_rel_inst", fs_to_ds_bus[63:32], memf(32'hBFC0_0010));

    // 4: branch stall for 2 cycles, then the target is released
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hBFC0_0200);
    checkOutput("t4_en0",    32'(inst_sram_en),   32'd0);
    checkOutput("t4_pc0",    fs_to_ds_bus[31:0],  32'hBFC0_0014);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hBFC0_0200);
    checkOutput("t4_en1",    32'(inst_sram_en),   32'd0);
    checkOutput("t4_bubble", 32'(fs_to_ds_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC0_0200);
    checkOutput("t4_en2",    32'(inst_sram_en),   32'd1);
    checkOutput("t4_addr",   inst_sram_addr,      32'hBFC0_0200);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_next",   inst_sram_addr,      32'hBFC0_0204);
    checkOutput("t4_pc",     fs_to_ds_bus[31:0],  32'hBFC0_0200);

    // 5: taken branch while IF is full and decode blocked; a later taken
    //    report with another target while one is parked is ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0300);
    checkOutput("t5_en0",    32'(inst_sram_en),   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0400);
    checkOutput("t5_en1",    32'(inst_sram_en),   32'd0);
    checkOutput("t5_hold",   fs_to_ds_bus[31:0],  32'hBFC0_0204);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_en2",    32'(inst_sram_en),   32'd1);
    checkOutput("t5_addr",   inst_sram_addr,      32'hBFC0_0300);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_clear",  inst_sram_addr,      32'hBFC0_0304);
    checkOutput("t5_pc",     fs_to_ds_bus[31:0],  32'hBFC0_0300);
    checkOutput("t5_inst",   fs_to_ds_bus[63:32], memf(32'hBFC0_0300));

    // 6: reset while a target is parked and the instruction is held
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0500);
    checkOutput("t6_en",     32'(inst_sram_en),   32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_rst_en", 32'(inst_sram_en),   32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_valid",  32'(fs_to_ds_valid), 32'd0);
    checkOutput("t6_addr",   inst_sram_addr,      32'hBFC0_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_addr1",  inst_sram_addr,      32'hBFC0_0004);
    checkOutput("t6_pc",     fs_to_ds_bus[31:0],  32'hBFC0_0000);
    checkOutput("t6_inst",   fs_to_ds_bus[63:32], memf(32'hBFC0_0000));

    // Address wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_tgt",  inst_sram_addr,      32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", inst_sram_addr,      32'h0000_0000);
    checkOutput("wrap_pc",   fs_to_ds_bus[31:0],  32'hFFFF_FFFC);

    checkOutput("no_0c",     32'(saw_0c),         32'd0);

    $display("[TB] directed sequence complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
